branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-order queue for in-flight branch predictions in the dual-issue pipeline. It records each fetched branch's PC and predicted direction, checks them against the resolved outcome at execute, and produces the redirect/flush pulse plus the per-slot training signals for the gshare predictor. Slot 1 is always older than slot 2 on both the enqueue and the resolve side.

## Interface
- DEPTH, 8: queue entries; power of two, at least 4.
- PTR_W, 3: log2(DEPTH).

- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- enq_valid_1 / enq_valid_2  in  1  fetch slot carries a branch
- enq_pc_1 / enq_pc_2  in  8  branch PC at fetch
- enq_pred_1 / enq_pred_2  in  1  predicted taken
- enq_ready  out  1  at least 2 free entries
- res_valid_1 / res_valid_2  in  1  execute slot resolves a branch
- res_pc_1 / res_pc_2  in  8  branch PC at execute
- res_taken_1 / res_taken_2  in  1  actual direction
- res_target_1 / res_target_2  in  8  taken target
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  8  correct next fetch PC, valid with flush
- upd_branch_1 / upd_branch_2  out  1  train predictor
- upd_pc_1 / upd_pc_2  out  8  PC to train
- upd_taken_1 / upd_taken_2  out  1  outcome to train
- branch_count  out  16  resolved branches, saturating
- mispredict_count  out  16  mispredicts, saturating
- err_overflow / err_underflow / err_pc_mismatch  out  1  sticky error flags

## Operation
- Storage: DEPTH entries of {pc[7:0], pred}, circular, with head and tail pointers of PTR_W bits and a count of PTR_W+1 bits. Pointers wrap modulo DEPTH.
- enq_ready = (DEPTH − count) ≥ 2. It is computed from the registered count only; dequeues in the same cycle do not free space.
- Enqueue: valid slots are written in order, slot 1 first. If only slot 2 is valid, it takes the tail entry.
  - Enqueue while enq_ready=0: entries are dropped and err_overflow is set.
- Resolve: valid slots consume the head entries in order (slot 1 = head, slot 2 = head+1; slot 2 alone = head).
  - Resolve beyond count: that slot is ignored and err_underflow is set.
  - Entry PC ≠ res_pc: err_pc_mismatch is set. The stored prediction is still used.
- Mispredict for a slot: stored pred ≠ res_taken.
  - Correct PC = res_target if taken, else res_pc+1 (8-bit, so 0xFF wraps to 0x00).
- Slot 1 mispredicts:
  - Slot 2's resolve is treated as wrong-path: no update, no count, no compare.
  - redirect_pc comes from slot 1.
- Only slot 2 mispredicts: redirect_pc comes from slot 2.
- On any mispredict:
  - At the next edge, the queue empties (head=tail, count=0).
  - All enqueues in that cycle are discarded.
- Update outputs: for every non-ignored, in-range resolved slot, upd_branch_x=1 with the resolved PC and direction. This applies whether the slot was predicted correctly or not.
- Counters: branch_count adds 0, 1 or 2 per cycle (non-ignored slots). mispredict_count adds 0 or 1. Both saturate at 0xFFFF.
- Error flags clear only on reset.

## Timing
- Reset (synchronous, reset=0 at an edge):
  - count, pointers, counters and error flags = 0.
  - flush=0, redirect_pc=0x00, all upd_*=0.
  - enq_ready=1 in the first cycle after reset.
- Enqueue: written at the edge; resolvable in the next cycle at the earliest.
- Resolve in cycle N:
  - flush, redirect_pc and upd_* are registered and valid in cycle N+1 for exactly one cycle.
  - Otherwise flush=0 and upd_branch_x=0.
- Flush cycle N+1: enqueues presented while flush=1 are discarded as wrong-path. Resolves in N+1 are likewise ignored.
- Simultaneous enqueue and resolve without mispredict: both apply at the same edge.
  - new count = count + enqueued − dequeued.
- Reset asserted mid-operation dominates all other inputs at that edge.

## Test plan
- Reset, then enqueue {0x10,pred=1} and {0x11,pred=0}; next cycle resolve both correctly (taken=1, taken=0) -> N+1: flush=0; upd_branch_1/2=1 with upd_pc 0x10/0x11 and upd_taken 1/0; branch_count=2; queue empty.
- Enqueue {0x20,pred=0} and {0x21,pred=1}; resolve slot 1 taken=1, target=0x40, with slot 2 valid -> N+1: flush=1, redirect_pc=0x40, upd_branch_1=1, upd_branch_2=0; mispredict_count=1, branch_count=1; count=0.
- Enqueue {0xFF,pred=1}; resolve taken=0 -> redirect_pc=0x00 (wrap); flush for one cycle; an enqueue presented during the flush cycle is dropped (count stays 0).
- Fill to DEPTH−1 entries -> enq_ready=0; enqueue two -> err_overflow=1, count unchanged. At DEPTH=8, 8 enqueue/dequeue cycles exercise pointer wrap with FIFO order intact.
- Resolve on empty queue -> err_underflow=1, upd_branch_1=0. Resolve with res_pc ≠ stored pc -> err_pc_mismatch=1; the update still issues.
- Drive 65540 correct resolutions -> branch_count saturates at 0xFFFF. Assert reset mid-stream -> all outputs and counters return to 0 at that edge.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// Bundle of the fetch-side enqueue, execute-side resolve and predictor-training
// signals of the branch resolve queue, plus queue-occupancy debug visibility.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
);
  // Enqueue handshake: a slot's entry is accepted at the edge where
  // enq_valid_x=1 and enq_ready=1 (and no flush/mispredict is in progress);
  // enq_ready never depends on enq_valid_x. Resolve slots have no back-pressure.
  logic             enq_valid_1, enq_valid_2;
  logic [7:0]       enq_pc_1, enq_pc_2;
  logic             enq_pred_1, enq_pred_2;
  logic             enq_ready;

  logic             res_valid_1, res_valid_2;
  logic [7:0]       res_pc_1, res_pc_2;
  logic             res_taken_1, res_taken_2;
  logic [7:0]       res_target_1, res_target_2;

  logic             flush;
  logic [7:0]       redirect_pc;
  logic             upd_branch_1, upd_branch_2;
  logic [7:0]       upd_pc_1, upd_pc_2;
  logic             upd_taken_1, upd_taken_2;
  logic [15:0]      branch_count;
  logic [15:0]      mispredict_count;
  logic             err_overflow, err_underflow, err_pc_mismatch;

  logic [PTR_W:0]   dbg_count;
  logic [PTR_W-1:0] dbg_head, dbg_tail;

  modport master (
    output enq_valid_1, enq_valid_2, enq_pc_1, enq_pc_2, enq_pred_1, enq_pred_2,
    output res_valid_1, res_valid_2, res_pc_1, res_pc_2, res_taken_1, res_taken_2,
    output res_target_1, res_target_2,
    input  enq_ready, flush, redirect_pc,
    input  upd_branch_1, upd_branch_2, upd_pc_1, upd_pc_2, upd_taken_1, upd_taken_2,
    input  branch_count, mispredict_count,
    input  err_overflow, err_underflow, err_pc_mismatch,
    input  dbg_count, dbg_head, dbg_tail
  );

  modport slave (
    input  enq_valid_1, enq_valid_2, enq_pc_1, enq_pc_2, enq_pred_1, enq_pred_2,
    input  res_valid_1, res_valid_2, res_pc_1, res_pc_2, res_taken_1, res_taken_2,
    input  res_target_1, res_target_2,
    output enq_ready, flush, redirect_pc,
    output upd_branch_1, upd_branch_2, upd_pc_1, upd_pc_2, upd_taken_1, upd_taken_2,
    output branch_count, mispredict_count,
    output err_overflow, err_underflow, err_pc_mismatch,
    output dbg_count, dbg_head, dbg_tail
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions for the dual-issue pipeline:
// checks predictions at execute, raises the redirect/flush pulse and trains gshare.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic                   clk,
  input logic                   reset,
  branch_resolve_queue_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

  logic [7:0]       q_pc   [DEPTH];
  logic             q_pred [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic             flush_q;
  logic [7:0]       redirect_q;
  logic             upd_b1_q, upd_b2_q, upd_t1_q, upd_t2_q;
  logic [7:0]       upd_pc1_q, upd_pc2_q;
  logic [15:0]      branch_count_q, mispredict_count_q;
  logic             err_ovf_q, err_unf_q, err_pcm_q;

  logic [PTR_W:0]   free_slots;
  logic             enq_ready;
  logic             live;
  logic [PTR_W-1:0] head_1, idx_2, tail_2;
  logic             s1_in, s1_act, s1_mis;
  logic             s2_in, s2_act, s2_mis;
  logic             mispredict;
  logic             underflow_evt, overflow_evt, pcm_evt;
  logic [7:0]       redirect_next;
  logic             enq_ok, we_1, we_2;
  logic [PTR_W:0]   n_deq, n_enq;
  logic [16:0]      bc_sum, mc_sum;

  // Readiness only looks at the registered count, never at same-cycle dequeues.
  assign free_slots = DEPTH_V - count;
  assign enq_ready  = free_slots >= (PTR_W+1)'(2);

  // Resolves arriving in the flush cycle belong to the wrong path.
  assign live   = !flush_q;
  assign head_1 = head + PTR_W'(1);

  assign s1_in  = bus.res_valid_1 && (count != '0);
  assign s1_act = live && s1_in;
  assign s1_mis = s1_act && (q_pred[head] != bus.res_taken_1);

  // Slot 2 takes head+1 behind a valid slot 1, otherwise the head itself.
  assign idx_2  = bus.res_valid_1 ? head_1 : head;
  assign s2_in  = bus.res_valid_1 ? (count >= (PTR_W+1)'(2)) : (count != '0);
  assign s2_act = live && bus.res_valid_2 && !s1_mis && s2_in;
  assign s2_mis = s2_act && (q_pred[idx_2] != bus.res_taken_2);

  assign mispredict = s1_mis || s2_mis;

  assign underflow_evt = live && ((bus.res_valid_1 && !s1_in) ||
                                  (bus.res_valid_2 && !s1_mis && !s2_in));
  assign pcm_evt       = (s1_act && (q_pc[head]  != bus.res_pc_1)) ||
                         (s2_act && (q_pc[idx_2] != bus.res_pc_2));
  assign overflow_evt  = (bus.enq_valid_1 || bus.enq_valid_2) && !enq_ready;

  always_comb begin
    redirect_next = 8'h00;
    if (s1_mis) begin
      redirect_next = bus.res_taken_1 ? bus.res_target_1 : bus.res_pc_1 + 8'd1;
    end else begin
      redirect_next = bus.res_taken_2 ? bus.res_target_2 : bus.res_pc_2 + 8'd1;
    end
  end

  assign n_deq = (PTR_W+1)'(s1_act) + (PTR_W+1)'(s2_act);

  // Any mispredict, or an outstanding flush, discards this cycle's fetch slots.
  assign enq_ok = enq_ready && live && !mispredict;
  assign we_1   = reset && enq_ok && bus.enq_valid_1;
  assign we_2   = reset && enq_ok && bus.enq_valid_2;
  assign n_enq  = (PTR_W+1)'(we_1) + (PTR_W+1)'(we_2);
  assign tail_2 = bus.enq_valid_1 ? tail + PTR_W'(1) : tail;

  assign bc_sum = {1'b0, branch_count_q} + 17'(n_deq);
  assign mc_sum = {1'b0, mispredict_count_q} + 17'(mispredict);

  always_ff @(posedge clk) begin
    if (we_1) begin
      q_pc[tail]   <= bus.enq_pc_1;
      q_pred[tail] <= bus.enq_pred_1;
    end
    if (we_2) begin
      q_pc[tail_2]   <= bus.enq_pc_2;
      q_pred[tail_2] <= bus.enq_pred_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + n_deq[PTR_W-1:0];
      tail  <= tail + n_enq[PTR_W-1:0];
      count <= count + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_q    <= 1'b0;
      redirect_q <= 8'h00;
      upd_b1_q   <= 1'b0;
      upd_b2_q   <= 1'b0;
      upd_t1_q   <= 1'b0;
      upd_t2_q   <= 1'b0;
      upd_pc1_q  <= 8'h00;
      upd_pc2_q  <= 8'h00;
    end else begin
      flush_q    <= mispredict;
      redirect_q <= mispredict ? redirect_next : redirect_q;
      upd_b1_q   <= s1_act;
      upd_b2_q   <= s2_act;
      upd_t1_q   <= s1_act && bus.res_taken_1;
      upd_t2_q   <= s2_act && bus.res_taken_2;
      upd_pc1_q  <= s1_act ? bus.res_pc_1 : 8'h00;
      upd_pc2_q  <= s2_act ? bus.res_pc_2 : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count_q     <= 16'h0000;
      mispredict_count_q <= 16'h0000;
      err_ovf_q          <= 1'b0;
      err_unf_q          <= 1'b0;
      err_pcm_q          <= 1'b0;
    end else begin
      branch_count_q     <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
      mispredict_count_q <= mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
      err_ovf_q          <= err_ovf_q || overflow_evt;
      err_unf_q          <= err_unf_q || underflow_evt;
      err_pcm_q          <= err_pcm_q || pcm_evt;
    end
  end

  assign bus.enq_ready        = enq_ready;
  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.upd_branch_1     = upd_b1_q;
  assign bus.upd_branch_2     = upd_b2_q;
  assign bus.upd_pc_1         = upd_pc1_q;
  assign bus.upd_pc_2         = upd_pc2_q;
  assign bus.upd_taken_1      = upd_t1_q;
  assign bus.upd_taken_2      = upd_t2_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.err_overflow     = err_ovf_q;
  assign bus.err_underflow    = err_unf_q;
  assign bus.err_pc_mismatch  = err_pcm_q;
  assign bus.dbg_count        = count;
  assign bus.dbg_head         = head;
  assign bus.dbg_tail         = tail;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based behavioural model through a scoreboard.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  bit   clk;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic           flush;
    logic [7:0]     redirect_pc;
    logic           upd_b1;
    logic [7:0]     upd_pc1;
    logic           upd_t1;
    logic           upd_b2;
    logic [7:0]     upd_pc2;
    logic           upd_t2;
    logic [15:0]    bc;
    logic [15:0]    mc;
    logic           ovf;
    logic           unf;
    logic           pcm;
    logic           ready;
    logic [PTR_W:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: queue of {pc, pred} entries, oldest first.
  logic [8:0] mq[$];
  int         m_bc, m_mc;
  bit         m_ovf, m_unf, m_pcm, m_flush;
  logic [7:0] m_redirect;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t       e;
    bit         ready, mis, act1, act2;
    int         pos, n;
    logic [8:0] ent;
    e = '0;
    if (reset === 1'b0) begin
      mq.delete();
      m_bc = 0; m_mc = 0;
      m_ovf = 0; m_unf = 0; m_pcm = 0; m_flush = 0;
      m_redirect = 8'h00;
      e.ready = 1'b1;
      exp_q.push_back(e);
      return;
    end
    ready = (DEPTH - mq.size()) >= 2;
    if ((bus.enq_valid_1 || bus.enq_valid_2) && !ready) m_ovf = 1;
    mis = 0; act1 = 0; act2 = 0;
    if (!m_flush) begin
      pos = bus.res_valid_1 ? 1 : 0;
      if (bus.res_valid_1) begin
        if (mq.size() > 0) begin
          act1 = 1;
          ent = mq[0];
          if (ent[8:1] != bus.res_pc_1) m_pcm = 1;
          if (ent[0] != bus.res_taken_1) begin
            mis = 1;
            m_redirect = bus.res_taken_1 ? bus.res_target_1 : 8'(bus.res_pc_1 + 8'd1);
          end
        end else m_unf = 1;
      end
      if (bus.res_valid_2 && !mis) begin
        if (pos < mq.size()) begin
          act2 = 1;
          ent = mq[pos];
          if (ent[8:1] != bus.res_pc_2) m_pcm = 1;
          if (ent[0] != bus.res_taken_2) begin
            mis = 1;
            m_redirect = bus.res_taken_2 ? bus.res_target_2 : 8'(bus.res_pc_2 + 8'd1);
          end
        end else m_unf = 1;
      end
    end
    n = int'(act1) + int'(act2);
    m_bc = (m_bc + n > 65535) ? 65535 : m_bc + n;
    if (mis) m_mc = (m_mc + 1 > 65535) ? 65535 : m_mc + 1;
    if (mis) mq.delete();
    else begin
      repeat (n) void'(mq.pop_front());
      if (ready && !m_flush) begin
        if (bus.enq_valid_1) mq.push_back({bus.enq_pc_1, bus.enq_pred_1});
        if (bus.enq_valid_2) mq.push_back({bus.enq_pc_2, bus.enq_pred_2});
      end
    end
    m_flush = mis;
    e.flush = mis;
    e.redirect_pc = m_redirect;
    e.upd_b1 = act1; e.upd_pc1 = bus.res_pc_1; e.upd_t1 = bus.res_taken_1;
    e.upd_b2 = act2; e.upd_pc2 = bus.res_pc_2; e.upd_t2 = bus.res_taken_2;
    e.bc = 16'(m_bc); e.mc = 16'(m_mc);
    e.ovf = m_ovf; e.unf = m_unf; e.pcm = m_pcm;
    e.ready = (DEPTH - mq.size()) >= 2;
    e.cnt = (PTR_W+1)'(mq.size());
    exp_q.push_back(e);
  endtask

  // Monitor: every negedge the DUT presents one registered output set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty: DUT output with no expected entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("flush", bus.flush, e.flush);
        if (e.flush) chk("redirect_pc", bus.redirect_pc, e.redirect_pc);
        chk("upd_branch_1", bus.upd_branch_1, e.upd_b1);
        if (e.upd_b1) begin
          chk("upd_pc_1", bus.upd_pc_1, e.upd_pc1);
          chk("upd_taken_1", bus.upd_taken_1, e.upd_t1);
        end
        chk("upd_branch_2", bus.upd_branch_2, e.upd_b2);
        if (e.upd_b2) begin
          chk("upd_pc_2", bus.upd_pc_2, e.upd_pc2);
          chk("upd_taken_2", bus.upd_taken_2, e.upd_t2);
        end
        chk("branch_count", bus.branch_count, e.bc);
        chk("mispredict_count", bus.mispredict_count, e.mc);
        chk("err_overflow", bus.err_overflow, e.ovf);
        chk("err_underflow", bus.err_underflow, e.unf);
        chk("err_pc_mismatch", bus.err_pc_mismatch, e.pcm);
        chk("enq_ready", bus.enq_ready, e.ready);
        chk("queue_count", bus.dbg_count, e.cnt);
      end
    end
  end

  task automatic idle();
    reset = 1'b1;
    bus.enq_valid_1 = 0; bus.enq_valid_2 = 0;
    bus.enq_pc_1 = 0; bus.enq_pc_2 = 0; bus.enq_pred_1 = 0; bus.enq_pred_2 = 0;
    bus.res_valid_1 = 0; bus.res_valid_2 = 0;
    bus.res_pc_1 = 0; bus.res_pc_2 = 0; bus.res_taken_1 = 0; bus.res_taken_2 = 0;
    bus.res_target_1 = 0; bus.res_target_2 = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
  endtask

  task automatic drv_enq(input bit v1, input logic [7:0] p1, input bit d1,
                         input bit v2, input logic [7:0] p2, input bit d2);
    bus.enq_valid_1 = v1; bus.enq_pc_1 = p1; bus.enq_pred_1 = d1;
    bus.enq_valid_2 = v2; bus.enq_pc_2 = p2; bus.enq_pred_2 = d2;
  endtask

  task automatic drv_res(input bit v1, input logic [7:0] p1, input bit t1, input logic [7:0] g1,
                         input bit v2, input logic [7:0] p2, input bit t2, input logic [7:0] g2);
    bus.res_valid_1 = v1; bus.res_pc_1 = p1; bus.res_taken_1 = t1; bus.res_target_1 = g1;
    bus.res_valid_2 = v2; bus.res_pc_2 = p2; bus.res_taken_2 = t2; bus.res_target_2 = g2;
  endtask

  task automatic rand_cycle();
    logic [8:0] ent;
    logic [7:0] pc;
    bit         v, t;
    int         idx;
    drv_enq(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int s = 0; s < 2; s++) begin
      v   = ($urandom_range(0, 3) != 0);
      idx = (s == 1 && bus.res_valid_1) ? 1 : 0;
      if (idx < mq.size()) begin
        ent = mq[idx];
        pc  = ent[8:1];
        t   = ent[0];
      end else begin
        pc = 8'($urandom);
        t  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) pc = pc ^ 8'h01;
      if ($urandom_range(0, 7) == 0) t = !t;
      if (s == 0) drv_res(v, pc, t, 8'($urandom), 0, 8'h00, 0, 8'h00);
      else begin
        bus.res_valid_2 = v; bus.res_pc_2 = pc; bus.res_taken_2 = t;
        bus.res_target_2 = 8'($urandom);
      end
    end
    if ($urandom_range(0, 299) == 0) reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [8:0] ent, ent2;
    idle();
    do_reset();
    chk("enq_ready_after_reset", bus.enq_ready, 1);

    // Two correct resolutions.
    drv_enq(1, 8'h10, 1, 1, 8'h11, 0); tick();
    drv_res(1, 8'h10, 1, 8'h80, 1, 8'h11, 0, 8'h00); tick();
    chk("t1_flush", bus.flush, 0);
    chk("t1_upd_pc_1", bus.upd_pc_1, 8'h10);
    chk("t1_upd_pc_2", bus.upd_pc_2, 8'h11);
    chk("t1_branch_count", bus.branch_count, 2);
    chk("t1_count", bus.dbg_count, 0);

    // Slot 1 mispredict squashes slot 2.
    do_reset();
    drv_enq(1, 8'h20, 0, 1, 8'h21, 1); tick();
    drv_res(1, 8'h20, 1, 8'h40, 1, 8'h21, 1, 8'h99); tick();
    chk("t2_flush", bus.flush, 1);
    chk("t2_redirect", bus.redirect_pc, 8'h40);
    chk("t2_upd_branch_2", bus.upd_branch_2, 0);
    chk("t2_mispredict_count", bus.mispredict_count, 1);
    chk("t2_branch_count", bus.branch_count, 1);
    tick();
    chk("t2_flush_one_cycle", bus.flush, 0);

    // Not-taken redirect wraps 0xFF to 0x00; enqueue during flush is dropped.
    drv_enq(1, 8'hFF, 1, 0, 8'h00, 0); tick();
    drv_res(1, 8'hFF, 0, 8'h12, 0, 8'h00, 0, 8'h00); tick();
    chk("t3_redirect_wrap", bus.redirect_pc, 8'h00);
    drv_enq(1, 8'h50, 1, 0, 8'h00, 0); tick();
    chk("t3_flush_off", bus.flush, 0);
    chk("t3_count", bus.dbg_count, 0);

    // Fill to DEPTH-1, overflow, then wrap the pointers in FIFO order.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_enq(1, 8'(8'h30 + 2 * i), i[0], 1, 8'(8'h31 + 2 * i), 1); tick();
    end
    drv_enq(1, 8'h3F, 0, 0, 8'h00, 0); tick();
    chk("t4_not_ready", bus.enq_ready, 0);
    drv_enq(1, 8'h70, 1, 1, 8'h71, 0); tick();
    chk("t4_overflow", bus.err_overflow, 1);
    chk("t4_count", bus.dbg_count, 7);
    for (int i = 0; i < 8; i++) begin
      ent = mq[0];
      drv_res(1, ent[8:1], ent[0], 8'h00, 0, 8'h00, 0, 8'h00);
      if (DEPTH - mq.size() >= 2) drv_enq(1, 8'(8'h60 + i), i[0], 0, 8'h00, 0);
      tick();
    end
    while (mq.size() > 0) begin
      ent = mq[0];
      drv_res(1, ent[8:1], ent[0], 8'h00, 0, 8'h00, 0, 8'h00);
      tick();
    end

    // Underflow and PC mismatch.
    do_reset();
    drv_res(1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00); tick();
    chk("t5_underflow", bus.err_underflow, 1);
    chk("t5_no_update", bus.upd_branch_1, 0);
    drv_enq(1, 8'h30, 0, 0, 8'h00, 0); tick();
    drv_res(1, 8'h31, 0, 8'h00, 0, 8'h00, 0, 8'h00); tick();
    chk("t5_pc_mismatch", bus.err_pc_mismatch, 1);
    chk("t5_update_issued", bus.upd_branch_1, 1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_cycle();
      tick();
    end

    // Saturate branch_count, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 32772; i++) begin
      drv_enq(1, 8'(2 * i), i[0], 1, 8'(2 * i + 1), i[1]);
      if (mq.size() >= 2) begin
        ent = mq[0]; ent2 = mq[1];
        drv_res(1, ent[8:1], ent[0], 8'h00, 1, ent2[8:1], ent2[0], 8'h00);
      end
      tick();
    end
    chk("sat_branch_count", bus.branch_count, 16'hFFFF);
    ent = mq[0]; ent2 = mq[1];
    drv_enq(1, 8'hA0, 1, 1, 8'hA1, 1);
    drv_res(1, ent[8:1], !ent[0], 8'h55, 1, ent2[8:1], ent2[0], 8'h00);
    reset = 1'b0;
    tick();
    chk("rst_branch_count", bus.branch_count, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_redirect", bus.redirect_pc, 8'h00);
    chk("rst_upd_branch_1", bus.upd_branch_1, 0);
    chk("rst_count", bus.dbg_count, 0);
    chk("rst_enq_ready", bus.enq_ready, 1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
